// File: rtl/cmd_defs.sv
// Shared frame constants, state encoding and serial CRC7 step for the SD CMD-line transmitter.
package cmd_defs;

   localparam int unsigned CMD_FRAME_BITS = 48;
   localparam int unsigned CMD_HDR_BITS   = 40;
   localparam int unsigned CMD_IDX_BITS   = 6;
   localparam int unsigned CMD_ARG_BITS   = 32;
   localparam int unsigned CRC7_BITS      = 7;
   localparam int unsigned CYC_W          = 8;
   localparam int unsigned BIT_W          = 6;

   localparam logic [CRC7_BITS-1:0] CRC7_POLY = 7'h09;

   // Frame bit positions (bit 0 is driven first)
   localparam logic [BIT_W-1:0] BIT_START    = 6'd0;
   localparam logic [BIT_W-1:0] BIT_LAST_HDR = BIT_W'(CMD_HDR_BITS - 1);
   localparam logic [BIT_W-1:0] BIT_END      = BIT_W'(CMD_FRAME_BITS - 1);

   localparam logic START_VAL = 1'b0;
   localparam logic TX_VAL    = 1'b1;
   localparam logic END_VAL   = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } cmd_state_e;

   typedef struct packed {
      logic                    start;
      logic                    tx;
      logic [CMD_IDX_BITS-1:0] index;
      logic [CMD_ARG_BITS-1:0] arg;
   } cmd_hdr_t;

   // One serial step of x^7+x^3+1, MSB-first data
   function automatic logic [CRC7_BITS-1:0] crc7_step(input logic [CRC7_BITS-1:0] crc,
                                                      input logic                 bit_in);
      logic fb;
      fb = bit_in ^ crc[CRC7_BITS-1];
      return {crc[CRC7_BITS-2:0], 1'b0} ^ (fb ? CRC7_POLY : '0);
   endfunction

endpackage

// File: rtl/cmd_crc7.sv
// Serial CRC7 accumulator; cleared at command accept, stepped once per header bit.
module cmd_crc7
   import cmd_defs::*;
(
   input  logic                 iClock,
   input  logic                 Reset,
   input  logic                 iClear,
   input  logic                 iEnable,
   input  logic                 iBit,
   output logic [CRC7_BITS-1:0] oCrc
);

   always_ff @(posedge iClock or negedge Reset) begin
      if (!Reset) begin
         oCrc <= '0;
      end else if (iClear) begin
         oCrc <= '0;
      end else if (iEnable) begin
         oCrc <= crc7_step(oCrc, iBit);
      end
   end

endmodule

// File: rtl/cmd_tx_serializer.sv
// Builds the 48-bit SD command frame and shifts it out MSB-first, then holds the line idle
// for a programmable gap before accepting the next command.
module cmd_tx_serializer
   import cmd_defs::*;
#(
   parameter int unsigned BIT_CYCLES = 1,
   parameter int unsigned GAP_BITS   = 8
) (
   input  logic                    iClock,
   input  logic                    Reset,
   input  logic                    iStart,
   input  logic [CMD_IDX_BITS-1:0] iIndex,
   input  logic [CMD_ARG_BITS-1:0] iArgument,
   output logic                    oReady,
   output logic                    oCmd,
   output logic                    oCmdOe,
   output logic                    oDone,
   output logic [BIT_W-1:0]        oBitCnt
);

   localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(BIT_CYCLES - 1);
   localparam logic [BIT_W-1:0] GAP_LAST = (GAP_BITS == 0) ? '0 : BIT_W'(GAP_BITS - 1);
   localparam int unsigned      PAD_BITS = CMD_HDR_BITS - CRC7_BITS - 1;

   cmd_state_e             state_q;
   cmd_state_e             state_d;
   cmd_hdr_t               sreg_q;
   cmd_hdr_t               sreg_d;
   logic [CYC_W-1:0]       cyc_q;
   logic [CYC_W-1:0]       cyc_d;
   logic [BIT_W-1:0]       gap_q;
   logic [BIT_W-1:0]       gap_d;
   logic [BIT_W-1:0]       bit_d;
   logic                   cmd_d;
   logic                   done_d;
   logic                   crc_clr;
   logic                   crc_en;
   logic [CRC7_BITS-1:0]   crc_q;
   logic [CRC7_BITS-1:0]   crc_fin;
   logic                   per_last;

   assign per_last = (cyc_q == CYC_LAST);
   // CRC including bit 39, needed in the same cycle bit 40 is loaded
   assign crc_fin  = crc7_step(crc_q, oCmd);

   cmd_crc7 u_crc (
      .iClock  (iClock),
      .Reset   (Reset),
      .iClear  (crc_clr),
      .iEnable (crc_en),
      .iBit    (oCmd),
      .oCrc    (crc_q)
   );

   always_ff @(posedge iClock or negedge Reset) begin
      if (!Reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (iStart) state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (per_last && (oBitCnt == BIT_END)) begin
               state_d = (GAP_BITS == 0) ? ST_IDLE : ST_GAP;
            end
         end
         ST_GAP: begin
            if (per_last && (gap_q == GAP_LAST)) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Next values of the shift path, counters and registered outputs
   always_comb begin
      sreg_d  = sreg_q;
      cyc_d   = cyc_q;
      gap_d   = gap_q;
      bit_d   = oBitCnt;
      cmd_d   = 1'b1;
      done_d  = 1'b0;
      crc_clr = 1'b0;
      crc_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (iStart) begin
               sreg_d  = '{start: START_VAL, tx: TX_VAL, index: iIndex, arg: iArgument};
               cmd_d   = START_VAL;
               cyc_d   = '0;
               bit_d   = BIT_START;
               crc_clr = 1'b1;
            end
         end
         ST_SHIFT: begin
            cmd_d  = oCmd;
            crc_en = per_last && (oBitCnt <= BIT_LAST_HDR);
            if (!per_last) begin
               cyc_d = cyc_q + CYC_W'(1);
            end else begin
               cyc_d = '0;
               if (oBitCnt == BIT_END) begin
                  bit_d  = '0;
                  cmd_d  = 1'b1;
                  done_d = 1'b1;
                  gap_d  = '0;
               end else begin
                  bit_d = oBitCnt + BIT_W'(1);
                  // After the header, the register is reloaded with CRC and the end bit
                  if (oBitCnt == BIT_LAST_HDR) begin
                     sreg_d = cmd_hdr_t'({crc_fin, END_VAL, {PAD_BITS{1'b0}}});
                     cmd_d  = crc_fin[CRC7_BITS-1];
                  end else begin
                     sreg_d = cmd_hdr_t'(sreg_q << 1);
                     cmd_d  = sreg_q[CMD_HDR_BITS-2];
                  end
               end
            end
         end
         ST_GAP: begin
            if (!per_last) begin
               cyc_d = cyc_q + CYC_W'(1);
            end else begin
               cyc_d = '0;
               gap_d = gap_q + BIT_W'(1);
            end
         end
         default: begin
            cyc_d = '0;
            bit_d = '0;
         end
      endcase
   end

   always_ff @(posedge iClock or negedge Reset) begin
      if (!Reset) begin
         sreg_q  <= '0;
         cyc_q   <= '0;
         gap_q   <= '0;
         oBitCnt <= '0;
         oCmd    <= 1'b1;
         oReady  <= 1'b1;
         oCmdOe  <= 1'b0;
         oDone   <= 1'b0;
      end else begin
         sreg_q  <= sreg_d;
         cyc_q   <= cyc_d;
         gap_q   <= gap_d;
         oBitCnt <= bit_d;
         oCmd    <= cmd_d;
         oReady  <= (state_d == ST_IDLE);
         oCmdOe  <= (state_d == ST_SHIFT);
         oDone   <= done_d;
      end
   end

endmodule

// File: tb/tb_cmd_tx_serializer.sv
// Bench for cmd_tx_serializer: three instances (1/8, 4/8, 1/0 bit-cycles/gap-bits) checked
// against a frame scoreboard, a vector table and hand-written reset/back-to-back sequences.
module tb_cmd_tx_serializer;

   typedef struct {
      int          inst;
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [47:0] frame;
      int          lat;
      int          gap;
   } vec_t;

   typedef struct packed {
      logic [1:0]  inst;
      logic [47:0] frame;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [2:0]       start = '0;
   logic [2:0][5:0]  idx = '0;
   logic [2:0][31:0] arg = '0;
   logic [2:0]       ready;
   logic [2:0]       cmd;
   logic [2:0]       oe;
   logic [2:0]       done;
   logic [2:0][5:0]  bitcnt;

   int   n_checks = 0;
   int   n_pass = 0;
   exp_t sb[$];
   int   ncyc[3];
   int   ndone[3];
   int   bad[3];
   logic smp[3][192];
   vec_t vecs[8];

   always #5 clk = ~clk;

   cmd_tx_serializer #(.BIT_CYCLES(1), .GAP_BITS(8)) u_dut0 (
      .iClock(clk), .Reset(rst_n), .iStart(start[0]), .iIndex(idx[0]), .iArgument(arg[0]),
      .oReady(ready[0]), .oCmd(cmd[0]), .oCmdOe(oe[0]), .oDone(done[0]), .oBitCnt(bitcnt[0]));

   cmd_tx_serializer #(.BIT_CYCLES(4), .GAP_BITS(8)) u_dut1 (
      .iClock(clk), .Reset(rst_n), .iStart(start[1]), .iIndex(idx[1]), .iArgument(arg[1]),
      .oReady(ready[1]), .oCmd(cmd[1]), .oCmdOe(oe[1]), .oDone(done[1]), .oBitCnt(bitcnt[1]));

   cmd_tx_serializer #(.BIT_CYCLES(1), .GAP_BITS(0)) u_dut2 (
      .iClock(clk), .Reset(rst_n), .iStart(start[2]), .iIndex(idx[2]), .iArgument(arg[2]),
      .oReady(ready[2]), .oCmd(cmd[2]), .oCmdOe(oe[2]), .oDone(done[2]), .oBitCnt(bitcnt[2]));

   function automatic int bc_of(input int i);
      return (i == 1) ? 4 : 1;
   endfunction

   // Reference frame: header, CRC7 by long division over the 40 header bits, end bit
   function automatic logic [47:0] frame_of(input logic [5:0] i, input logic [31:0] a);
      logic [39:0] h;
      logic [6:0]  c;
      h = {2'b01, i, a};
      c = '0;
      for (int k = 39; k >= 0; k--) begin
         if (h[k] ^ c[6]) c = {c[5:0], 1'b0} ^ 7'h09;
         else             c = {c[5:0], 1'b0};
      end
      return {h, c, 1'b1};
   endfunction

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
   endtask

   task automatic finish_frame(input int i);
      logic [47:0] f;
      int          hold_bad;
      int          bc;
      exp_t        e;
      bc       = bc_of(i);
      f        = '0;
      hold_bad = 0;
      chk("frame_len", 64'(ncyc[i]), 64'(48 * bc));
      for (int c = 0; c < ncyc[i] && c < 192; c++) begin
         if (smp[i][c] !== smp[i][(c / bc) * bc]) hold_bad++;
      end
      for (int k = 0; k < 48; k++) begin
         if (k * bc < 192) f[47-k] = smp[i][k*bc];
      end
      chk("bit_hold_and_bitcnt", 64'(hold_bad + bad[i]), 64'd0);
      chk("done_after_end", 64'(done[i]), 64'd1);
      chk("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("frame_inst", 64'(i), 64'(e.inst));
         chk("frame", 64'(f), 64'(e.frame));
      end
      bad[i] = 0;
   endtask

   // Collects driven bits per instance and scores each frame when the drive enable drops
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (!rst_n) begin
            ncyc[i] = 0;
            bad[i]  = 0;
         end else begin
            if (done[i]) ndone[i]++;
            if (oe[i]) begin
               if (ncyc[i] < 192) begin
                  smp[i][ncyc[i]] = cmd[i];
                  if (bitcnt[i] !== 6'(ncyc[i] / bc_of(i))) bad[i]++;
               end
               ncyc[i]++;
            end else if (ncyc[i] != 0) begin
               finish_frame(i);
               ncyc[i] = 0;
            end
         end
      end
   end

   task automatic push_exp(input int i, input logic [47:0] f);
      exp_t e;
      e.inst  = 2'(i);
      e.frame = f;
      sb.push_back(e);
   endtask

   task automatic wait_ready(input int i);
      int n;
      n = 0;
      while (!ready[i] && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", 64'(ready[i]), 64'd1);
   endtask

   task automatic run_vec(input vec_t v);
      int n;
      int g;
      int d0;
      wait_ready(v.inst);
      d0 = ndone[v.inst];
      start[v.inst] = 1'b1;
      idx[v.inst]   = v.idx;
      arg[v.inst]   = v.arg;
      push_exp(v.inst, v.frame);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            start[v.inst] = 1'b0;
            idx[v.inst]   = ~v.idx;
            arg[v.inst]   = ~v.arg;
         end
         if (n == 5) begin
            start[v.inst] = 1'b1;
            arg[v.inst]   = 32'($urandom);
         end
         if (n == 6) start[v.inst] = 1'b0;
      end while (!done[v.inst] && n < 1000);
      chk("latency_to_done", 64'(n), 64'(v.lat));
      g = 0;
      while (!ready[v.inst] && g < 1000) begin
         @(negedge clk);
         g++;
      end
      chk("gap_cycles", 64'(g), 64'(v.gap));
      @(negedge clk);
      chk("done_pulse_count", 64'(ndone[v.inst] - d0), 64'd1);
   endtask

   initial begin
      int n;
      int d0;
      vecs[0] = '{0, 6'd0,  32'h0000_0000, 48'h40_0000_0000_95, 49,  8};
      vecs[1] = '{0, 6'd17, 32'h0000_0000, 48'h51_0000_0000_55, 49,  8};
      vecs[2] = '{0, 6'd8,  32'h0000_01AA, 48'h48_0000_01AA_87, 49,  8};
      vecs[3] = '{1, 6'd0,  32'h0000_0000, 48'h40_0000_0000_95, 193, 32};
      vecs[4] = '{2, 6'd8,  32'h0000_01AA, 48'h48_0000_01AA_87, 49,  0};
      vecs[5] = '{0, 6'd55, 32'h0000_0000, frame_of(6'd55, 32'h0), 49, 8};
      vecs[6] = '{1, 6'h29, 32'h40FF_8000, frame_of(6'h29, 32'h40FF_8000), 193, 32};
      vecs[7] = '{0, 6'h3F, 32'hFFFF_FFFF, frame_of(6'h3F, 32'hFFFF_FFFF), 49, 8};

      // Reset values, both while held and right after release
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++)
         chk("reset_outputs", 64'({ready[i], cmd[i], oe[i], done[i], bitcnt[i]}), 64'(10'b11_0000_0000));
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++)
         chk("idle_outputs", 64'({ready[i], cmd[i], oe[i], done[i], bitcnt[i]}), 64'(10'b11_0000_0000));

      for (int v = 0; v < 8; v++) run_vec(vecs[v]);

      // Reset in the middle of a CMD8 frame on instance 0
      wait_ready(0);
      d0       = ndone[0];
      start[0] = 1'b1;
      idx[0]   = 6'd8;
      arg[0]   = 32'h0000_01AA;
      push_exp(0, 48'h48_0000_01AA_87);
      @(negedge clk);
      start[0] = 1'b0;
      n = 0;
      while (bitcnt[0] != 6'd20 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("reached_bit20", 64'(bitcnt[0]), 64'd20);
      rst_n = 1'b0;
      #1;
      chk("async_reset_outputs", 64'({ready[0], cmd[0], oe[0], done[0], bitcnt[0]}), 64'(10'b11_0000_0000));
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (60) @(negedge clk);
      chk("no_done_after_abort", 64'(ndone[0] - d0), 64'd0);
      run_vec(vecs[0]);

      // Back-to-back on the zero-gap instance with iStart held high
      wait_ready(2);
      d0       = ndone[2];
      start[2] = 1'b1;
      idx[2]   = 6'd0;
      arg[2]   = 32'h0;
      push_exp(2, 48'h40_0000_0000_95);
      @(negedge clk);
      idx[2]   = 6'd8;
      arg[2]   = 32'h0000_01AA;
      push_exp(2, 48'h48_0000_01AA_87);
      n = 0;
      while (!done[2] && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_first_done", 64'(n), 64'd48);
      @(negedge clk);
      chk("b2b_second_starts", 64'({oe[2], cmd[2], ready[2]}), 64'(3'b100));
      start[2] = 1'b0;
      n = 0;
      while (!done[2] && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("b2b_second_done", 64'(n), 64'd48);
      @(negedge clk);
      chk("b2b_done_pulses", 64'(ndone[2] - d0), 64'd2);

      repeat (5) @(negedge clk);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cmd_tx_serializer.md
Name: cmd_tx_serializer

Overview:
- Downstream stage of the command generator `cmd`.
- Takes a 6-bit command index and the 32-bit argument `cmd` produces.
- Builds the 48-bit SD CMD-line frame: start, transmission, index, argument, CRC7, end.
- Shifts the frame out MSB-first on a single serial line, then enforces an inter-command gap before accepting the next command.

Parameters:
- BIT_CYCLES, 1: clock cycles each serial bit is held on oCmd (valid range 1..255).
- GAP_BITS, 8: bit periods of forced idle after the end bit, before oReady returns (valid range 0..63).

Ports:
- iClock  input  1  system clock, all state on rising edge
- Reset  input  1  asynchronous, active-low reset
- iStart  input  1  request to send; sampled only when oReady=1
- iIndex  input  6  command index, captured with iStart
- iArgument  input  32  command argument, captured with iStart
- oReady  output  1  high only in IDLE; a command may be accepted
- oCmd  output  1  serial CMD line value
- oCmdOe  output  1  line drive enable; high only while frame bits are driven
- oDone  output  1  one-cycle pulse after the end bit completes
- oBitCnt  output  6  index of the frame bit currently driven (0..47), 0 when not shifting

Behaviour:
- Reset (Reset=0, async, immediate):
  - State = IDLE.
  - oReady=1, oCmd=1, oCmdOe=0, oDone=0, oBitCnt=0.
  - Shift register, CRC and counters cleared.
- Reset asserted mid-frame or mid-gap:
  - Frame is aborted, no oDone.
  - Line returns to 1 / Oe=0 in the same instant.
- Frame layout, bit 0 first:
  - bit 0 = 0 (start)
  - bit 1 = 1 (transmission)
  - bits 2..7 = iIndex[5:0], MSB first
  - bits 8..39 = iArgument[31:0], MSB first
  - bits 40..46 = CRC7[6:0], MSB first
  - bit 47 = 1 (end)
- CRC7:
  - Polynomial x^7+x^3+1, initial value 0.
  - Computed serially over bits 0..39, updated as each bit is driven.
- State IDLE:
  - oReady=1, oCmdOe=0, oCmd=1.
  - On iStart=1, capture the {2'b01, iIndex, iArgument} 40-bit header, clear CRC, go to SHIFT.
- State SHIFT:
  - First cycle after acceptance drives bit 0.
  - Each bit is held exactly BIT_CYCLES clocks; oCmdOe=1 throughout.
  - Latency from the iStart cycle to start bit on oCmd: 1 clock.
  - Total frame duration: 48*BIT_CYCLES clocks.
- Transition SHIFT -> GAP:
  - Happens after bit 47's last cycle.
  - oDone=1 for exactly the first GAP cycle, or the first IDLE cycle if GAP_BITS=0.
- State GAP:
  - oCmd=1, oCmdOe=0, oReady=0, for GAP_BITS*BIT_CYCLES clocks, then IDLE.
- iStart while oReady=0 is ignored; no queuing.
- Inputs may change after the accept cycle without affecting the frame in flight.
- Back-to-back with GAP_BITS=0: iStart in the IDLE cycle carrying oDone is accepted; the next start bit follows with no extra idle cycles.
- Bit and cycle counters never wrap. The bit counter saturates by FSM exit at 47; the cycle counter reloads per bit.

Decomposition:
- Shared package/include `cmd_defs`:
  - Frame constants: CMD_FRAME_BITS=48, CMD_HDR_BITS=40, CRC7_POLY=7'h09.
  - Field bit positions.
  - State encodings IDLE/SHIFT/GAP.
- One sub-module: `cmd_crc7`.
  - Serial CRC7 with iClock, Reset, iClear, iEnable, iBit, oCrc[6:0].
  - Instantiated once; enabled only on the last cycle of each bit period for bits 0..39.

Test Plan:
- CMD0, iIndex=0, iArgument=32'h0, BIT_CYCLES=1 -> oCmd sequence equals 48'h40_0000_0000_95, oDone pulse at clock 49 after iStart, oCmdOe high exactly 48 cycles.
- CMD17, iIndex=17, iArgument=32'h0 -> frame 48'h51_0000_0000_55; CMD8, iIndex=8, iArgument=32'h0000_01AA -> frame 48'h48_0000_01AA_87.
- BIT_CYCLES=4, GAP_BITS=8, CMD0 -> each bit held 4 clocks, frame lasts 192 clocks, oReady stays 0 for 32 further clocks after oDone.
- iStart held high continuously with GAP_BITS=0, two commands (CMD0 then CMD8) -> second start bit directly follows first end bit, no dropped or duplicated bits, two oDone pulses.
- Reset pulled low at bit 20 of a CMD8 frame -> oCmd=1, oCmdOe=0, oReady=1 immediately, no oDone; a CMD0 issued after release produces the correct 0x40...95 frame.
- iStart pulsed and iArgument changed while busy -> ignored; frame in flight unchanged.
